// File: rtl/line_mem_responder.sv
// Line-oriented memory model answering pmem read/write requests after a fixed LATENCY.
// Optional macro LINE_MEM_RESPONDER_STATS_EN adds saturating completed-read/write counters.
module line_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pmem_address,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         proto_err,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
);

    localparam int         NUM_LINES = 2 ** INDEX_BITS;
    localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]   addr_q, addr_d;
    logic [255:0]            wdata_q, wdata_d;
    logic                    is_write_q, is_write_d;
    logic [255:0]            rdata_q, rdata_d;
    logic                    proto_err_q, proto_err_d;
    logic                    mem_we;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [255:0]            mem_q [NUM_LINES];

    // Upper address bits alias onto the same lines and the byte offset is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pmem_address[31:INDEX_BITS+5], pmem_address[4:0]};
    assign req_idx          = pmem_address[INDEX_BITS+4:5];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_write_d  = is_write_q;
        rdata_d     = rdata_q;
        proto_err_d = proto_err_q;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    addr_d     = req_idx;
                    wdata_d    = pmem_wdata;
                    is_write_d = pmem_write;
                    cnt_d      = LAT_M1;
                    if (pmem_read && pmem_write) begin
                        proto_err_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        if (!pmem_write) begin
                            rdata_d = mem_q[req_idx];
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (is_write_q ? !pmem_write : !pmem_read) begin
                    proto_err_d = 1'b1;
                end
                // Read data is loaded on entry to RESP so it is valid alongside pmem_resp.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                    if (!is_write_q) begin
                        rdata_d = mem_q[addr_q];
                    end
                end
            end
            RESP: begin
                mem_we  = is_write_q;
                state_d = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_write_q  <= 1'b0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_write_q  <= is_write_d;
            rdata_q     <= rdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage survives reset; a reset coinciding with RESP suppresses the commit.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign pmem_resp  = (state_q == RESP);
    assign pmem_rdata = rdata_q;
    assign proto_err  = proto_err_q;

`ifdef LINE_MEM_RESPONDER_STATS_EN
    logic [15:0] read_count_q, read_count_d;
    logic [15:0] write_count_q, write_count_d;

    always_comb begin
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if (state_q == RESP) begin
            if (is_write_q && (write_count_q != 16'hFFFF)) begin
                write_count_d = write_count_q + 16'd1;
            end
            if (!is_write_q && (read_count_q != 16'hFFFF)) begin
                read_count_d = read_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_count_q  <= 16'd0;
            write_count_q <= 16'd0;
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`else
    assign read_count  = 16'd0;
    assign write_count = 16'd0;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed self-checking bench for line_mem_responder (LATENCY=4, INDEX_BITS=5).
module tb_line_mem_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         proto_err;
    logic [15:0]  read_count;
    logic [15:0]  write_count;

    int errors = 0;
    int checks = 0;
    int exp_reads = 0;
    int exp_writes = 0;

    line_mem_responder #(.LATENCY(LAT), .INDEX_BITS(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .proto_err    (proto_err),
        .read_count   (read_count),
        .write_count  (write_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Counter expectations follow the model only when the stats build is enabled.
    task automatic checkCounts(input string tag);
        logic [15:0] exp_rc;
        logic [15:0] exp_wc;
`ifdef LINE_MEM_RESPONDER_STATS_EN
        exp_rc = 16'(exp_reads);
        exp_wc = 16'(exp_writes);
`else
        exp_rc = 16'd0;
        exp_wc = 16'd0;
`endif
        checkOutput({tag, "_read_count"}, 256'(read_count), 256'(exp_rc));
        checkOutput({tag, "_write_count"}, 256'(write_count), 256'(exp_wc));
    endtask

    // Drives one transaction from IDLE, checks response latency and the pulse falling,
    // and returns with the DUT back in IDLE. drop_at > 0 releases the request after that many edges.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [255:0] wd, input int drop_at, input string tag,
                                 output logic [255:0] rd_seen);
        int n;
        bit seen;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        seen = 0;
        n    = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == drop_at) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            if (pmem_resp) seen = 1;
        end
        checkOutput({tag, "_latency"}, 256'(seen ? n : 0), 256'(LAT));
        rd_seen    = pmem_rdata;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        if (seen) begin
            if (wr) exp_writes++;
            else    exp_reads++;
        end
        @(posedge clk); #1;
        checkOutput({tag, "_resp_fall"}, 256'(pmem_resp), 256'(0));
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'd0;
        pmem_wdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        exp_reads  = 0;
        exp_writes = 0;
    endtask

    initial begin
        logic [255:0] rd;
        logic [255:0] val_a5;
        logic [255:0] val_x;
        logic [255:0] val_y;
        logic [255:0] val_w;
        logic [255:0] val_z;
        logic [255:0] val_v;
        logic [255:0] val_f;
        int n;
        int t1;
        int t2;
        int pulses;

        val_a5 = {32{8'hA5}};
        val_x  = {8{32'hDEADBEEF}};
        val_y  = {8{32'h12345678}};
        val_w  = {16{16'hCAFE}};
        val_z  = {32{8'h3C}};
        val_v  = {8{32'h0BADF00D}};
        val_f  = {32{8'h0F}};

        doReset();
        checkOutput("reset_resp", 256'(pmem_resp), 256'(0));
        checkOutput("reset_rdata", pmem_rdata, '0);
        checkOutput("reset_proto_err", 256'(proto_err), 256'(0));
        checkCounts("reset");

        applyStimulus(1'b0, 1'b1, 32'h0000_0040, val_a5, 0, "wr40", rd);
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, '0, 0, "rd40", rd);
        checkOutput("rd40_data", rd, val_a5);

        applyStimulus(1'b0, 1'b1, 32'h0000_0100, {32{8'h11}}, 0, "wr100", rd);
        checkOutput("rdata_hold_on_write", pmem_rdata, val_a5);

        applyStimulus(1'b0, 1'b1, 32'h0000_0020, val_x, 0, "wr20", rd);
        applyStimulus(1'b1, 1'b0, 32'h0000_0420, '0, 0, "rd420", rd);
        checkOutput("alias_data", rd, val_x);
        checkOutput("alias_proto_err", 256'(proto_err), 256'(0));

        applyStimulus(1'b1, 1'b1, 32'h0000_0060, val_y, 0, "both60", rd);
        checkOutput("both_proto_err", 256'(proto_err), 256'(1));
        applyStimulus(1'b1, 1'b0, 32'h0000_0060, '0, 0, "rd60", rd);
        checkOutput("both_data", rd, val_y);
        checkOutput("proto_err_sticky", 256'(proto_err), 256'(1));

        // Reset in WAIT of a write must abort it without a pulse or a commit.
        applyStimulus(1'b0, 1'b1, 32'h0000_0080, val_w, 0, "wr80", rd);
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0080;
        pmem_wdata   = val_z;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst        = 1'b1;
        pmem_write = 1'b0;
        @(posedge clk); #1;
        exp_reads  = 0;
        exp_writes = 0;
        checkOutput("abort_resp", 256'(pmem_resp), 256'(0));
        checkOutput("abort_rdata", pmem_rdata, '0);
        checkOutput("abort_proto_err", 256'(proto_err), 256'(0));
        checkCounts("abort");
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (pmem_resp) pulses++;
        end
        checkOutput("abort_no_pulse", 256'(pulses), 256'(0));
        applyStimulus(1'b1, 1'b0, 32'h0000_0080, '0, 0, "rd80", rd);
        checkOutput("abort_keeps_old", rd, val_w);

        applyStimulus(1'b0, 1'b1, 32'h0000_00C0, val_v, 0, "wrC0", rd);
        applyStimulus(1'b1, 1'b0, 32'h0000_00C0, '0, 0, "rdC0", rd);
        checkOutput("b2b_data", rd, val_v);
        applyStimulus(1'b0, 1'b1, 32'h0000_00E0, val_f, 0, "wrE0", rd);
        applyStimulus(1'b1, 1'b0, 32'h0000_00E0, '0, 0, "rdE0", rd);
        checkOutput("rdE0_data", rd, val_f);
        checkCounts("stats");

        // Request held through HOLD is accepted again with LATENCY+2 pulse spacing.
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_0040;
        t1 = 0;
        t2 = 0;
        n  = 0;
        while (t2 == 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (pmem_resp) begin
                if (t1 == 0) t1 = n;
                else         t2 = n;
            end
        end
        pmem_read = 1'b0;
        exp_reads += 2;
        checkOutput("held_first_latency", 256'(t1), 256'(LAT));
        checkOutput("held_spacing", 256'(t2 - t1), 256'(LAT + 2));
        checkOutput("held_data", pmem_rdata, val_a5);
        checkOutput("held_proto_err", 256'(proto_err), 256'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;

        applyStimulus(1'b1, 1'b0, 32'h0000_00C0, '0, 1, "drop", rd);
        checkOutput("drop_data", rd, val_v);
        checkOutput("drop_proto_err", 256'(proto_err), 256'(1));
        checkCounts("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
